// File: rtl/data_buf_ctrl_pkg.sv
// Shared types and config-clamping helpers for the data_buf tile sequencer.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
`ifndef ROW_CNT
`define ROW_CNT 8
`endif
`ifndef ADDR_BW
`define ADDR_BW 3
`endif

package data_buf_ctrl_pkg;

    localparam int REP_BW_DEF = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } state_t;

    // A zero or oversize length means "use the whole buffer".
    function automatic int clamp_len(input int len, input int row_cnt);
        return ((len == 0) || (len > row_cnt)) ? row_cnt : len;
    endfunction

    // A tile is always replayed at least once.
    function automatic int clamp_rep(input int rep);
        return (rep == 0) ? 1 : rep;
    endfunction

endpackage

// File: rtl/data_buf_ctrl_wrap_cnt.sv
// Up-counter with enable, synchronous clear and programmable last value.
// Latency: count updates on the clock edge after i_en; o_wrap is combinational.
// Backpressure: holds its value whenever i_en is low.
module wrap_cnt #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_en,
    input  logic         i_clr,
    input  logic [W-1:0] i_wrap_val,
    output logic [W-1:0] o_cnt,
    output logic         o_wrap
);

    logic [W-1:0] r_cnt;

    assign o_cnt  = r_cnt;
    assign o_wrap = (r_cnt == i_wrap_val);

    // Count up, returning to zero after the last value; clear wins over enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_wrap ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/data_buf_ctrl.sv
// Tile sequencer: fills data_buf from the loader, then replays the tile rep times to the MAC.
// Latency: FILL one cycle after cfg_start; STREAM the cycle after the last row is written; read latency 0.
// Backpressure: in_valid gaps stall the write counter, mac_ready low holds rd_addr; abort wins over all.
`ifndef ROW_CNT
`define ROW_CNT 8
`endif
`ifndef ADDR_BW
`define ADDR_BW 3
`endif

module data_buf_ctrl
    import data_buf_ctrl_pkg::*;
#(
    parameter int ROW_CNT = `ROW_CNT,
    parameter int ADDR_BW = `ADDR_BW,
    parameter int REP_BW  = REP_BW_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_start,
    input  logic [ADDR_BW:0]   cfg_len,
    input  logic [REP_BW-1:0]  cfg_rep,
    input  logic               abort,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               wr_en,
    output logic [ADDR_BW-1:0] wr_addr,
    input  logic               mac_ready,
    output logic               out_valid,
    output logic               rd_en,
    output logic [ADDR_BW-1:0] rd_addr,
    output logic               out_pass_last,
    output logic               out_tile_last,
    output logic               tile_done,
    output logic               busy
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ADDR_BW:0]   r_len;
    logic [REP_BW-1:0]  r_rep;
    logic [REP_BW-1:0]  r_pass;
    logic [ADDR_BW-1:0] w_last_row;
    logic               w_wr_fire;
    logic               w_rd_fire;
    logic               w_wr_wrap;
    logic               w_rd_wrap;
    logic               w_last_pass;

    // len is clamped to 1..ROW_CNT, so len-1 always fits the row address.
    assign w_last_row  = ADDR_BW'(r_len - 1'b1);
    assign w_wr_fire   = (r_state == FILL) && in_valid;
    assign w_rd_fire   = (r_state == STREAM) && mac_ready;
    assign w_last_pass = (r_pass == REP_BW'(r_rep - 1'b1));

    assign rd_en = out_valid;
    assign busy  = (r_state != IDLE);

    wrap_cnt #(.W(ADDR_BW)) u_wr_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_en       (w_wr_fire),
        .i_clr      (abort),
        .i_wrap_val (w_last_row),
        .o_cnt      (wr_addr),
        .o_wrap     (w_wr_wrap)
    );

    wrap_cnt #(.W(ADDR_BW)) u_rd_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_en       (w_rd_fire),
        .i_clr      (abort),
        .i_wrap_val (w_last_row),
        .o_cnt      (rd_addr),
        .o_wrap     (w_rd_wrap)
    );

    // Latch clamped tile config on a start seen in IDLE; abort wipes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len <= '0;
            r_rep <= '0;
        end else if (abort) begin
            r_len <= '0;
            r_rep <= '0;
        end else if ((r_state == IDLE) && cfg_start) begin
            r_len <= (ADDR_BW+1)'(clamp_len(int'(cfg_len), ROW_CNT));
            r_rep <= REP_BW'(clamp_rep(int'(cfg_rep)));
        end
    end

    // Count completed passes; reset it on the way out so the next tile starts at pass 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pass <= '0;
        end else if (abort || (r_state == DONE)) begin
            r_pass <= '0;
        end else if (w_rd_fire && w_rd_wrap) begin
            r_pass <= r_pass + 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and buffer/handshake outputs; abort overrides every transition.
    always_comb begin
        w_state_nxt   = r_state;
        in_ready      = 1'b0;
        wr_en         = 1'b0;
        out_valid     = 1'b0;
        out_pass_last = 1'b0;
        out_tile_last = 1'b0;
        tile_done     = 1'b0;
        case (r_state)
            IDLE: begin
                if (cfg_start) begin
                    w_state_nxt = FILL;
                end
            end
            FILL: begin
                in_ready = 1'b1;
                wr_en    = in_valid;
                if (in_valid && w_wr_wrap) begin
                    w_state_nxt = STREAM;
                end
            end
            STREAM: begin
                out_valid     = 1'b1;
                out_pass_last = w_rd_wrap;
                out_tile_last = w_rd_wrap && w_last_pass;
                if (mac_ready && w_rd_wrap && w_last_pass) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                tile_done   = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        if (abort) begin
            w_state_nxt = IDLE;
        end
    end

endmodule

// File: doc/data_buf_ctrl.md
# data_buf_ctrl

Tile sequencer for the row-organised `data_buf` in the bMAC_SIMD kernel. Accepts one tile of rows from an upstream loader over a valid/ready handshake and generates the buffer's write controls. Then replays the tile to the MAC array a configurable number of times, generating the buffer's read controls under MAC backpressure. One tile in flight at a time; the buffer is never read and written in the same state.

## Interface
Parameters:
- `ROW_CNT`, default `` `ROW_CNT ``: rows in `data_buf`.
- `ADDR_BW`, default `` `ADDR_BW ``: row address width, ≥ clog2(ROW_CNT).
- `REP_BW`, default 8: replay-count width.

Ports (clock and reset: one clock; reset is asynchronous and active-low):
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous reset, active low.
- `cfg_start`  in  1  start new tile; sampled only in IDLE.
- `cfg_len`  in  ADDR_BW+1  rows per tile; sampled with `cfg_start`.
- `cfg_rep`  in  REP_BW  number of read passes; sampled with `cfg_start`.
- `abort`  in  1  synchronous abort, any state.
- `in_valid`  in  1  loader row valid.
- `in_ready`  out  1  controller accepts row.
- `wr_en`  out  1  to `data_buf` `wr_en`.
- `wr_addr`  out  ADDR_BW  to `data_buf` `wr_addr`.
- `mac_ready`  in  1  MAC array consumes current row.
- `out_valid`  out  1  `data_buf` `oData` is a valid row.
- `rd_en`  out  1  to `data_buf` `rd_en`; equals `out_valid`.
- `rd_addr`  out  ADDR_BW  to `data_buf` `rd_addr`.
- `out_pass_last`  out  1  current row is the last of a pass.
- `out_tile_last`  out  1  current row is the last of the final pass.
- `tile_done`  out  1  one-cycle pulse after the final row is consumed.
- `busy`  out  1  state ≠ IDLE.

## Operation
- States: IDLE, FILL, STREAM, DONE.
- **IDLE**
  - On `cfg_start`, latch len and rep, then go to FILL.
  - Clamping: len = 0 or len > ROW_CNT becomes ROW_CNT; rep = 0 becomes 1.
- **FILL**
  - `in_ready` = 1.
  - `wr_en` = `in_valid & in_ready`.
  - `wr_addr` = write counter, starting at 0 and incrementing on each accepted row.
  - When row len−1 is accepted, go to STREAM and clear the write counter.
- **STREAM**
  - `out_valid` = `rd_en` = 1.
  - `rd_addr` = read counter, starting at 0. It holds while `mac_ready` = 0 and increments on `out_valid & mac_ready`.
  - At row len−1:
    - `out_pass_last` = 1.
    - On consume, wrap the read counter to 0 and increment the pass counter.
    - If the consumed pass was pass rep, go to DONE.
  - `out_tile_last` = `out_pass_last` && pass counter = rep−1.
- **DONE**
  - `tile_done` = 1 for exactly one cycle, then go to IDLE.
- **abort**
  - From any state, go to IDLE next cycle.
  - Clear all counters and latched config.
  - No `tile_done`.
  - Abort has priority over every other transition in the same cycle.
- `cfg_start` outside IDLE is ignored; config registers hold.
- All outputs are functions of registered state and counters only, except `wr_en`, which also depends on `in_valid`.
- Counter widths:
  - Write and read counters: ADDR_BW.
  - Pass counter: REP_BW.
  - No overflow is possible after clamping.

## Timing
- Reset values:
  - State IDLE.
  - All counters and latched config 0.
  - `in_ready`, `wr_en`, `wr_addr`, `out_valid`, `rd_en`, `rd_addr`, `out_pass_last`, `out_tile_last`, `tile_done` and `busy` all 0.
- `cfg_start` at cycle 0 gives FILL and `in_ready` = 1 at cycle 1.
- `data_buf` write lands at the rising edge ending the `wr_en` cycle.
- Last row accepted in cycle t:
  - STREAM at t+1, `out_valid` = 1, `rd_addr` = 0.
  - The last written row is visible because the `data_buf` read is combinational from the registered array.
- Read latency is 0: `oData` is valid in the same cycle as `rd_addr` and `out_valid`.
- With `mac_ready` held at 1, one row per cycle. A tile with len L and rep R streams in exactly L×R cycles, then DONE for 1 cycle, then IDLE.
- Minimum tile turnaround (`cfg_start` to IDLE with `in_valid` and `mac_ready` tied high): 1 + L + L×R + 1 cycles.
- Reset asserted mid-operation returns everything to reset values immediately (asynchronously). Buffer contents are not guaranteed after reset.

## Structure
- `data_buf_ctrl_pkg` contains:
  - `state_t` enum {IDLE, FILL, STREAM, DONE}.
  - `clamp_len` and `clamp_rep` functions.
  - The REP_BW default constant.
- Optional sub-module `wrap_cnt`: an up-counter with enable, synchronous clear, programmable wrap value and a `wrap` flag. Instantiated for the write and read counters.
- The controller top level instantiates nothing else. `data_buf` is instantiated alongside it by the kernel top.

## Test plan
- Basic: reset, `cfg_start` with len=4, rep=2, `in_valid` and `mac_ready` = 1.
  - Expect `wr_addr` 0..3 on cycles 1–4.
  - Expect `rd_addr` 0,1,2,3,0,1,2,3 on cycles 5–12, with `out_pass_last` on cycles 8 and 12 and `out_tile_last` on 12.
  - Expect `tile_done` on 13 and `busy` = 0 on 14.
- Backpressure: len=3, rep=1, random `in_valid` and `mac_ready` gaps.
  - Each row is written once, in address order.
  - `rd_addr` holds while `mac_ready` = 0.
  - Rows are read back in order with data matching the writes.
- Clamping:
  - len=0, rep=0 gives ROW_CNT rows written, 1 pass, `tile_done` once.
  - len = ROW_CNT+5 behaves identically.
- Ignored start: `cfg_start` with len=1 pulsed during FILL and STREAM of a len=4 tile. Latched len stays 4 and the pass completes normally.
- Abort: `abort` at the second STREAM cycle together with `mac_ready` = 1.
  - IDLE next cycle, `out_valid` = 0, no `tile_done`.
  - A following `cfg_start` starts a clean FILL at `wr_addr` 0.
- Async reset: assert `rst_n` = 0 mid-FILL, between clock edges. All outputs read 0 before the next edge, and state is IDLE after release.
